bcd2binary_seq: RTL
===================

Name: bcd2binary_seq

Overview:
- Multi-cycle BCD-to-binary converter; the inverse of the display-side binary-to-BCD path.
- Takes DIGITS packed BCD digits, such as a price or credit entered on the vending-machine keypad, and returns the binary value for the credit/price arithmetic.
- Uses reverse double-dabble: shift right one bit per clock, then subtract 3 from every BCD digit that is >= 8.
- Uses a start/busy/done handshake and rejects non-BCD digits.

Parameters:
- DIGITS, 3, number of BCD digits in; digit 0 = ones, in bcd_in[3:0].
- BIN_W, 10, binary output width. Must satisfy 2^BIN_W >= 10^DIGITS. Also sets the conversion length in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion; sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD digits: hundreds in [11:8], tens in [7:4], ones in [3:0].
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when result/err are updated.
- binary  out  BIN_W  converted value; held until the next accepted start.
- err  out  1  last request contained a digit > 9; held like binary.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, busy=0, done=0, binary=0, err=0, shift register=0, count=0. Applies at any time, including mid-conversion; the partial result is discarded and no done is produced.
- FSM states: IDLE, CONV, DONE.
- IDLE: on an edge with start=1, capture bcd_in.
  - Any digit > 9: go to DONE, set err=1, binary=0.
  - Otherwise: load the shift register, {bcd_in, BIN_W zeros} (4*DIGITS+BIN_W bits), count=0, go to CONV.
- IDLE, start=0: remain in IDLE.
- CONV: busy=1. Each edge performs:
  - shift the whole register right by 1;
  - then, in the same cycle, for every digit field of the shifted value, if digit >= 8, digit = digit - 3 (4-bit, no borrow across digits);
  - count++.
- CONV exit: after BIN_W such edges (count reaches BIN_W-1 on the last), go to DONE. On that same edge, load binary from the low BIN_W bits of the post-shift value and set err=0.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
  - A start in the DONE cycle is ignored.
  - A new start is accepted from the following IDLE cycle.
- Latency:
  - valid input: done is high in the cycle after the BIN_W-th CONV edge, i.e. BIN_W+1 edges after the start-sampling edge (11 for defaults);
  - invalid input: done is high after 1 edge.
- start while busy=1: ignored; bcd_in changes during CONV have no effect.
- Held outputs: binary and err change only on the transition into DONE. done and busy are never high together.
- Range: all-9 input gives 10^DIGITS-1 (999 for defaults). No overflow is possible given the BIN_W constraint.

Decomposition:
- Shared package bcd_pkg:
  - state encoding (IDLE, CONV, DONE);
  - BCD_W=4, BCD_MAX=9, CORR_THRESH=8, CORR_VAL=3;
  - a function for minimum binary width.
  - The display-side converter reuses BCD_W and the constants (its threshold is 5).
- Sub-module bcd_digit_corr: purely combinational, 4-bit in/out, output = in>=8 ? in-3 : in. Instantiated DIGITS times via generate.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset then bcd_in=0x255, start pulse -> busy for 10 cycles; done pulse 11 edges after start; binary=255 (0x0FF); err=0.
- bcd_in=0x999 -> binary=999 (0x3E7). bcd_in=0x000 -> binary=0. Both with done at the same latency.
- bcd_in=0x1A3, start -> done after 1 edge; err=1, binary=0; busy never asserted. A following 0x123 conversion -> binary=123, err=0.
- Start 0x042; during CONV, change bcd_in to 0x777 and pulse start twice -> single done, binary=42. No second conversion unless start is held in a later IDLE cycle.
- Start 0x500; assert rst_n=0 at cycle 5 of CONV -> busy/done/binary/err go to 0 immediately (asynchronous). After release, no done occurs until a new start.
- Back-to-back: hold start=1 continuously with 0x100 -> done pulses every 12 cycles (IDLE, 10×CONV, DONE), binary=100 each time.

Source files
------------

// File: rtl/bcd2binary_seq_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion blocks (keypad-side
// BCD-to-binary and display-side binary-to-BCD).
//   state_e      : FSM state encoding (IDLE, CONV, DONE)
//   BCD_W        : bits per BCD digit
//   BCD_MAX      : largest legal BCD digit value
//   CORR_THRESH  : digit value at or above which the reverse double-dabble
//                  correction applies (the display-side converter uses 5)
//   CORR_VAL     : amount subtracted by the correction
//   min_bin_w()  : minimum binary width able to hold 10^digits - 1
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BCD_W       = 4;
    localparam int BCD_MAX     = 9;
    localparam int CORR_THRESH = 8;
    localparam int CORR_VAL    = 3;

    // Smallest w with 2^w >= 10^digits.
    function automatic int min_bin_w(input int digits);
        longint p;
        int     w;
        p = 1;
        w = 0;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        for (int k = 0; k < 63; k++) begin
            if ((64'd1 << k) >= p) begin
                w = k;
                break;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2binary_seq_if.sv
// ----------------------------------------------------------------------------
// bcd2binary_seq_if
// Request/result bundle of the BCD-to-binary converter.
//   start   : request a conversion (driven by master)
//   bcd_in  : packed BCD digits, digit 0 = ones in [3:0] (driven by master)
//   busy    : conversion in progress (driven by slave)
//   done    : one-cycle pulse when binary/err are updated (driven by slave)
//   binary  : converted value, held (driven by slave)
//   err     : last request held a digit > 9, held (driven by slave)
// ----------------------------------------------------------------------------
interface bcd2binary_seq_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    binary;
    logic                err;

    modport master (
        output start, bcd_in,
        input  busy, done, binary, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, binary, err
    );
endinterface

// File: rtl/bcd2binary_seq_digit_corr.sv
// ----------------------------------------------------------------------------
// bcd_digit_corr
// Combinational per-digit correction for reverse double-dabble: after the
// right shift, any digit that reached 8 or more carried a half-ten from the
// digit above and is pulled back by 3.
//   digit_i : shifted 4-bit digit field
//   digit_o : corrected digit field
// ----------------------------------------------------------------------------
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_W'(CORR_THRESH)) ? (digit_i - BCD_W'(CORR_VAL))
                                                       : digit_i;

endmodule

// File: rtl/bcd2binary_seq.sv
// ----------------------------------------------------------------------------
// bcd2binary_seq
// Multi-cycle BCD-to-binary converter (reverse double-dabble, one bit per
// clock). Non-BCD digits are rejected in a single cycle with err=1.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd2binary_seq_if (start/bcd_in in,
//           busy/done/binary/err out)
// ----------------------------------------------------------------------------
module bcd2binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd2binary_seq_if.slave    bus
);

    localparam int BCD_BITS = BCD_W * DIGITS;
    localparam int SR_W     = BCD_BITS + BIN_W;
    localparam int CNT_W    = $clog2(BIN_W + 1);

    state_e           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;

    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  sr_corr;
    logic             bcd_bad;

    // Shift first, then correct the BCD fields of the shifted value; the
    // binary bits below them pass straight through.
    assign sr_shift              = sr_q >> 1;
    assign sr_corr[BIN_W-1:0]    = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_digit_corr u_corr (
            .digit_i (sr_shift[BIN_W + g*BCD_W +: BCD_W]),
            .digit_o (sr_corr [BIN_W + g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) begin
                bcd_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bcd_bad) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        bin_d   = '0;
                    end else begin
                        sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_corr;
                cnt_d = cnt_q + CNT_W'(1);
                // Last of BIN_W shifts: result is complete in the low bits.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                    bin_d   = sr_corr[BIN_W-1:0];
                    err_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy   = (state_q == CONV);
    assign bus.done   = (state_q == DONE);
    assign bus.binary = bin_q;
    assign bus.err    = err_q;

endmodule
